// File: rtl/jtframe_ioctl_pkg.sv
// Shared definitions for the ioctl download stream consumers.
//  IOCTL_AW    width of the framework byte address bus
//  state_t     loader FSM states
//  lane_count  bytes per PROM word for a given word width
//  lane_bits   log2 of the lane count
package jtframe_ioctl_pkg;

  localparam int IOCTL_AW = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bytes needed to build one PROM word of width dw.
  function automatic int lane_count(input int dw);
    if (dw <= 8)       return 1;
    else if (dw <= 16) return 2;
    else               return 4;
  endfunction

  // Number of low address bits that select the lane inside a word.
  function automatic int lane_bits(input int wb);
    if (wb == 1)      return 0;
    else if (wb == 2) return 1;
    else              return 2;
  endfunction

endpackage

// File: rtl/jtframe_prom_loader.sv
// Write-side companion of an on-chip PROM. Watches the byte-wide ioctl
// download stream, keeps the bytes that fall inside this PROM's address
// window, packs them little-endian into DW-bit words and issues one write
// strobe per completed word. A partial word left when the download ends is
// flushed with FILL in the missing lanes. A mod-256 checksum of accepted
// bytes and a done flag are reported.
//
// Ports
//  clk          system clock
//  rst          synchronous reset, active high
//  downloading  download in progress (level)
//  ioctl_addr   byte address of the current download byte
//  ioctl_dout   download byte
//  ioctl_wr     one-cycle byte strobe
//  prom_addr    PROM write address
//  prom_data    PROM write data
//  prom_we      one-cycle PROM write strobe
//  done         PROM fully loaded for the current download
//  checksum     mod-256 sum of accepted bytes
module jtframe_prom_loader
  import jtframe_ioctl_pkg::*;
#(
  parameter int                    DW    = 8,
  parameter int                    AW    = 10,
  parameter logic [IOCTL_AW-1:0]   START = '0,
  parameter logic [7:0]            FILL  = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 downloading,
  input  logic [IOCTL_AW-1:0]  ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  input  logic                 ioctl_wr,
  output logic [AW-1:0]        prom_addr,
  output logic [DW-1:0]        prom_data,
  output logic                 prom_we,
  output logic                 done,
  output logic [7:0]           checksum
);

  localparam int WB  = lane_count(DW);
  localparam int LW  = lane_bits(WB);
  // Lane index is kept at least one bit wide so byte-wide PROMs still have
  // a legal (always zero) lane signal.
  localparam int LIW = (LW > 0) ? LW : 1;

  // Window size in bytes, one bit wider than the bus so the exclusive end
  // of a window reaching the top of the address space is still representable.
  localparam logic [IOCTL_AW:0]    WIN_SIZE   = (IOCTL_AW + 1)'(WB) << AW;
  localparam logic [LIW-1:0]       LANE_MASK  = LIW'(WB - 1);
  localparam logic [WB-1:0][7:0]   FILL_LANES = {WB{FILL}};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t               state_q,     state_d;
  logic                 dl_q,        dl_d;
  logic [WB-1:0][7:0]   lanes_q,     lanes_d;
  logic                 pend_q,      pend_d;
  logic [AW-1:0]        pend_word_q, pend_word_d;
  logic [AW-1:0]        prom_addr_q, prom_addr_d;
  logic [DW-1:0]        prom_data_q, prom_data_d;
  logic                 prom_we_q,   prom_we_d;
  logic                 done_q,      done_d;
  logic [7:0]           checksum_q,  checksum_d;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [IOCTL_AW:0]    rel;
  logic                 in_win;
  logic [LIW-1:0]       lane;
  logic [AW-1:0]        word;
  logic                 dl_rise;
  logic                 dl_fall;
  logic                 accept;
  logic                 last_lane;
  logic [WB-1:0][7:0]   merged;

  // The lower bound is checked on the raw address; the upper bound on the
  // offset, so an address one past the window can never wrap to word 0.
  assign rel       = {1'b0, ioctl_addr} - {1'b0, START};
  assign in_win    = (ioctl_addr >= START) && (rel < WIN_SIZE);
  assign lane      = rel[LIW-1:0] & LANE_MASK;
  assign word      = AW'(rel >> LW);
  assign dl_rise   = downloading & ~dl_q;
  assign dl_fall   = ~downloading & dl_q;
  assign accept    = (state_q == LOAD) && ioctl_wr && in_win;
  assign last_lane = (lane == LANE_MASK);

  // Little-endian packing: lane k lands on bits [8k+7:8k], then the word is
  // truncated to DW, which also drops the upper bits of each byte when DW<8.
  function automatic logic [DW-1:0] pack_word(input logic [WB-1:0][7:0] lanes);
    logic [31:0] w;
    w = {4{FILL}};
    for (int k = 0; k < WB; k++) begin
      w[8*k +: 8] = lanes[k];
    end
    return w[DW-1:0];
  endfunction

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    dl_d        = downloading;
    lanes_d     = lanes_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    prom_addr_d = prom_addr_q;
    prom_data_d = prom_data_q;
    prom_we_d   = 1'b0;
    done_d      = done_q;
    checksum_d  = checksum_q;
    merged      = lanes_q;

    case (state_q)
      IDLE, DONE: begin
        // done follows the state one cycle late, so it rises the cycle after
        // the final write strobe rather than alongside it.
        done_d = (state_q == DONE);
        if (dl_rise) begin
          state_d    = LOAD;
          lanes_d    = FILL_LANES;
          pend_d     = 1'b0;
          checksum_d = 8'h00;
          done_d     = 1'b0;
        end
      end

      LOAD: begin
        if (accept) begin
          checksum_d = checksum_q + ioctl_dout;
          // Jumping to another word before finishing this one drops the
          // partial bytes without writing them.
          if (pend_q && (word != pend_word_q)) begin
            merged = FILL_LANES;
          end
          for (int k = 0; k < WB; k++) begin
            if (lane == LIW'(k)) begin
              merged[k] = ioctl_dout;
            end
          end
          if (last_lane) begin
            prom_we_d   = 1'b1;
            prom_addr_d = word;
            prom_data_d = pack_word(merged);
            lanes_d     = FILL_LANES;
            pend_d      = 1'b0;
          end else begin
            lanes_d     = merged;
            pend_d      = 1'b1;
            pend_word_d = word;
          end
        end
        // A byte arriving on the falling cycle is already folded into
        // pend_d above, so the flush decision sees it.
        if (dl_fall) begin
          state_d = pend_d ? FLUSH : DONE;
        end
      end

      FLUSH: begin
        prom_we_d   = 1'b1;
        prom_addr_d = pend_word_q;
        prom_data_d = pack_word(lanes_q);
        lanes_d     = FILL_LANES;
        pend_d      = 1'b0;
        state_d     = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dl_q        <= 1'b0;
      // NOTE: the lane buffer is a handful of flops, not a RAM, so it is
      // reset like any other register; FILL keeps flushed lanes defined.
      lanes_q     <= FILL_LANES;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      prom_addr_q <= '0;
      prom_data_q <= '0;
      prom_we_q   <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      lanes_q     <= lanes_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      prom_addr_q <= prom_addr_d;
      prom_data_q <= prom_data_d;
      prom_we_q   <= prom_we_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
    end
  end

  assign prom_addr = prom_addr_q;
  assign prom_data = prom_data_q;
  assign prom_we   = prom_we_q;
  assign done      = done_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_jtframe_prom_loader.sv
// Directed bench for jtframe_prom_loader. Four instances share the download
// bus but each has its own downloading/ioctl_wr, so only one is active at a
// time. Expected PROM writes are queued as bytes are driven and compared as
// each prom_we appears.
module tb_jtframe_prom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  dl  = 4'h0;
  logic [3:0]  wr  = 4'h0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;

  wire  [3:0]  we_v;
  wire  [3:0]  done_v;
  wire  [3:0]  a0, a1, a2, a3;
  wire  [7:0]  d8;
  wire  [3:0]  d4;
  wire  [15:0] d16;
  wire  [31:0] d32;
  wire  [7:0]  cs0, cs1, cs2, cs3;

  always #5 clk = ~clk;

  jtframe_prom_loader #(.DW(8),  .AW(4), .START(25'h100), .FILL(8'h00)) u_dw8 (
    .clk(clk), .rst(rst), .downloading(dl[0]), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(wr[0]), .prom_addr(a0), .prom_data(d8),
    .prom_we(we_v[0]), .done(done_v[0]), .checksum(cs0));

  jtframe_prom_loader #(.DW(4),  .AW(4), .START(25'h100), .FILL(8'h00)) u_dw4 (
    .clk(clk), .rst(rst), .downloading(dl[1]), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(wr[1]), .prom_addr(a1), .prom_data(d4),
    .prom_we(we_v[1]), .done(done_v[1]), .checksum(cs1));

  jtframe_prom_loader #(.DW(16), .AW(4), .START(25'h100), .FILL(8'hFF)) u_dw16 (
    .clk(clk), .rst(rst), .downloading(dl[2]), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(wr[2]), .prom_addr(a2), .prom_data(d16),
    .prom_we(we_v[2]), .done(done_v[2]), .checksum(cs2));

  jtframe_prom_loader #(.DW(32), .AW(4), .START(25'h100), .FILL(8'h00)) u_dw32 (
    .clk(clk), .rst(rst), .downloading(dl[3]), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(wr[3]), .prom_addr(a3), .prom_data(d32),
    .prom_we(we_v[3]), .done(done_v[3]), .checksum(cs3));

  typedef struct packed {
    logic [1:0]  idx;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  time  last_we_t[4];
  time  done_rise_t[4];
  logic [3:0] done_prev = 4'h0;

  function automatic logic [3:0] addr_of(input int i);
    case (i)
      0:       return a0;
      1:       return a1;
      2:       return a2;
      default: return a3;
    endcase
  endfunction

  function automatic logic [31:0] data_of(input int i);
    case (i)
      0:       return {24'h0, d8};
      1:       return {28'h0, d4};
      2:       return {16'h0, d16};
      default: return d32;
    endcase
  endfunction

  function automatic logic [7:0] cs_of(input int i);
    case (i)
      0:       return cs0;
      1:       return cs1;
      2:       return cs2;
      default: return cs3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every prom_we seen must match the oldest queued write.
  task automatic monitor();
    wr_t e;
    for (int i = 0; i < 4; i++) begin
      if (done_v[i] && !done_prev[i]) done_rise_t[i] = $time;
      done_prev[i] = done_v[i];
      if (we_v[i]) begin
        last_we_t[i] = $time;
        check($sformatf("we_expected_dut%0d", i), {31'h0, exp_q.size() != 0}, 32'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("we_dut%0d", i), {26'h0, 2'(i), addr_of(i)}, {26'h0, e.idx, e.addr});
          check($sformatf("we_data_dut%0d", i), data_of(i), e.data);
        end
      end
    end
  endtask

  // Advance n cycles; inputs change and outputs are read 1 time unit after
  // the rising edge, the scoreboard runs on the falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int idx, input int addr, input logic [31:0] data);
    exp_q.push_back('{idx: 2'(idx), addr: 4'(addr), data: data});
  endtask

  task automatic send(input int idx, input logic [24:0] addr, input logic [7:0] data);
    ioctl_addr = addr;
    ioctl_dout = data;
    wr[idx]    = 1'b1;
    tick(1);
    wr[idx]    = 1'b0;
  endtask

  task automatic start_dl(input int idx);
    dl[idx] = 1'b1;
    tick(1);
  endtask

  // Bounded wait for done, then confirm all writes landed before it rose.
  task automatic wait_done(input int idx, input string tag);
    int n = 0;
    while (!done_v[idx] && n < 20) begin
      tick(1);
      n++;
    end
    check({tag, "_done"}, {31'h0, done_v[idx]}, 32'h1);
    tick(1);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    check({tag, "_done_after_we"}, {31'h0, done_rise_t[idx] > last_we_t[idx]}, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      last_we_t[i]   = 0;
      done_rise_t[i] = 0;
    end

    // Reset values on every instance
    tick(2);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_we_%0d", i),   {31'h0, we_v[i]},   32'h0);
      check($sformatf("rst_addr_%0d", i), {28'h0, addr_of(i)}, 32'h0);
      check($sformatf("rst_data_%0d", i), data_of(i),          32'h0);
      check($sformatf("rst_done_%0d", i), {31'h0, done_v[i]}, 32'h0);
      check($sformatf("rst_cs_%0d", i),   {24'h0, cs_of(i)},   32'h0);
    end

    // Byte-wide PROM: 16 bytes fill words 0..15
    start_dl(0);
    for (int i = 0; i < 16; i++) begin
      push(0, i, 32'(i));
      send(0, 25'h100 + 25'(i), 8'(i));
    end
    dl[0] = 1'b0;
    wait_done(0, "dw8_full");
    check("dw8_checksum", {24'h0, cs0}, 32'h78);

    // 4-bit PROM: low nibble kept, bytes just outside the window ignored
    start_dl(1);
    push(1, 0, 32'h7);
    send(1, 25'h100, 8'hA7);
    send(1, 25'h0FF, 8'h11);
    send(1, 25'h110, 8'h22);
    dl[1] = 1'b0;
    wait_done(1, "dw4_window");
    check("dw4_checksum", {24'h0, cs1}, 32'hA7);

    // 16-bit PROM: one full word, then a half word flushed with FILL
    start_dl(2);
    push(2, 0, 32'h1234);
    push(2, 1, 32'hFF78);
    send(2, 25'h100, 8'h34);
    send(2, 25'h101, 8'h12);
    send(2, 25'h102, 8'h78);
    dl[2] = 1'b0;
    wait_done(2, "dw16_flush");
    check("dw16_checksum", {24'h0, cs2}, 32'hBE);

    // 16-bit PROM again: abandoned partial word is dropped, checksum wraps
    start_dl(2);
    check("dw16_done_drop", {31'h0, done_v[2]}, 32'h0);
    push(2, 4, 32'hEFCD);
    send(2, 25'h106, 8'hAB);
    send(2, 25'h108, 8'hCD);
    send(2, 25'h109, 8'hEF);
    dl[2] = 1'b0;
    wait_done(2, "dw16_discard");
    check("dw16_checksum_wrap", {24'h0, cs2}, 32'h67);

    // Second download on the byte-wide PROM with the last byte on the
    // falling cycle: write next cycle, done one cycle after that
    start_dl(0);
    check("dw8_done_drop", {31'h0, done_v[0]}, 32'h0);
    check("dw8_cs_restart", {24'h0, cs0}, 32'h0);
    push(0, 5, 32'h5A);
    ioctl_addr = 25'h105;
    ioctl_dout = 8'h5A;
    wr[0]      = 1'b1;
    dl[0]      = 1'b0;
    tick(1);
    wr[0]      = 1'b0;
    check("fall_we", {31'h0, we_v[0]}, 32'h1);
    check("fall_done_low", {31'h0, done_v[0]}, 32'h0);
    tick(1);
    check("fall_done_high", {31'h0, done_v[0]}, 32'h1);
    check("fall_we_low", {31'h0, we_v[0]}, 32'h0);
    check("fall_checksum", {24'h0, cs0}, 32'h5A);
    tick(1);
    check("fall_pending", exp_q.size(), 0);

    // 32-bit PROM: reset after three of four bytes aborts the word
    start_dl(3);
    send(3, 25'h100, 8'hDE);
    send(3, 25'h101, 8'hAD);
    send(3, 25'h102, 8'hBE);
    rst   = 1'b1;
    dl[3] = 1'b0;
    tick(1);
    check("abort_we",   {31'h0, we_v[3]},  32'h0);
    check("abort_addr", {28'h0, a3},       32'h0);
    check("abort_data", d32,               32'h0);
    check("abort_done", {31'h0, done_v[3]}, 32'h0);
    check("abort_cs",   {24'h0, cs3},      32'h0);
    rst = 1'b0;
    tick(2);
    check("abort_no_we", {31'h0, we_v[3]}, 32'h0);
    start_dl(3);
    push(3, 1, 32'h44332211);
    send(3, 25'h104, 8'h11);
    send(3, 25'h105, 8'h22);
    send(3, 25'h106, 8'h33);
    send(3, 25'h107, 8'h44);
    dl[3] = 1'b0;
    wait_done(3, "dw32_reload");
    check("dw32_checksum", {24'h0, cs3}, 32'hAA);

    tick(3);
    check("final_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
